spi_fifo_master: RTL

- Parametrised successor to the single-byte SPI path of the multi-protocol bridge.
- SPI master with configurable frame width, NUM_CS chip selects, and TX/RX FIFOs of DEPTH entries.
- Back-to-back frames under one CS assertion (burst mode).
- Sticky error flags for the register block; sits between the AXI-Lite register slave and the SPI pins.

---
 rtl/spi_fifo_pkg.sv | 25 ++
 rtl/spi_fifo_master_sync_fifo.sv | 58 +++++
 rtl/spi_fifo_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fifo_pkg.sv
// Shared FSM state type, SPI mode encodings and width helper for the SPI FIFO master.
package spi_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_fifo_master_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push while full and pop while empty are ignored.
module sync_fifo
  import spi_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push_c, do_pop_c;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_c = push_i & ~full_o;
  assign do_pop_c  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(do_push_c) - LW'(do_pop_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_fifo_master.sv
// SPI master with TX/RX FIFOs, burst frames under one chip select and sticky error flags.
// Optional SPI_LOOPBACK_EN adds cfg_loopback, which samples internal MOSI instead of MISO.
module spi_fifo_master
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CS     = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  localparam int unsigned CS_W  = (clog2(NUM_CS) > 0) ? clog2(NUM_CS) : 1,
  localparam int unsigned LVL_W = clog2(DEPTH) + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic                  tx_wvalid,
  output logic                  tx_wready,
  output logic [DATA_WIDTH-1:0] rx_rdata,
  output logic                  rx_rvalid,
  input  logic                  rx_rready,
  input  logic                  cfg_en,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [CS_W-1:0]       cfg_cs_sel,
  input  logic                  clr_err,
  output logic                  busy,
  output logic [LVL_W-1:0]      tx_level,
  output logic [LVL_W-1:0]      rx_level,
  output logic                  err_tx_ovf,
  output logic                  err_rx_udf,
  output logic                  frame_done,
  output logic                  SCLK,
  output logic                  MOSI,
`ifdef SPI_LOOPBACK_EN
  input  logic                  cfg_loopback,
`endif
  input  logic                  MISO,
  output logic [NUM_CS-1:0]     CSn
);

  localparam int unsigned       EDGE_W    = clog2(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [DATA_WIDTH-1:0] txsh_q, txsh_d, rxsh_q, rxsh_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NUM_CS-1:0]     csn_q, csn_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_tx_ovf_q, err_tx_ovf_d, err_rx_udf_q, err_rx_udf_d;

  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_pop_c, rx_push_c;
  logic                  tick_c, can_start_c, lead_c, sample_c, update_c, miso_bit_c;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b, input logic lsb);
    return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i(ACLK), .rst_i(ARESET), .push_i(tx_wvalid), .wdata_i(tx_wdata), .pop_i(tx_pop_c),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i(ACLK), .rst_i(ARESET), .push_i(rx_push_c), .wdata_i(rxsh_d), .pop_i(rx_rready),
    .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  assign tx_wready   = ~tx_full;
  assign rx_rvalid   = ~rx_empty;
  assign busy        = (state_q != IDLE);
  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign CSn         = csn_q;
  assign frame_done  = frame_done_q;
  assign err_tx_ovf  = err_tx_ovf_q;
  assign err_rx_udf  = err_rx_udf_q;
  assign tick_c      = (cnt_q == div_q - DIV_WIDTH'(1));
  assign can_start_c = cfg_en & ~tx_empty & ~rx_full;
  assign lead_c      = ~edge_q[0];

`ifdef SPI_LOOPBACK_EN
  assign miso_bit_c = cfg_loopback ? mosi_q : MISO;
`else
  assign miso_bit_c = MISO;
`endif

  // First bit is preloaded, so CPHA=1 skips the MOSI update on the very first leading edge
  always_comb begin
    sample_c = lead_c;
    update_c = 1'b0;
    case ({cpol_q, cpha_q})
      MODE0, MODE2: begin
        sample_c = lead_c;
        update_c = ~lead_c & (edge_q != EDGE_LAST);
      end
      MODE1, MODE3: begin
        sample_c = ~lead_c;
        update_c = lead_c & (edge_q != '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    edge_d       = edge_q;
    txsh_d       = txsh_q;
    rxsh_d       = rxsh_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    lsb_d        = lsb_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    csn_d        = csn_q;
    frame_done_d = 1'b0;
    tx_pop_c     = 1'b0;
    rx_push_c    = 1'b0;
    err_tx_ovf_d = (tx_wvalid & tx_full) | (err_tx_ovf_q & ~clr_err);
    err_rx_udf_d = (rx_rready & rx_empty) | (err_rx_udf_q & ~clr_err);

    if (state_q != IDLE) cnt_d = tick_c ? '0 : cnt_q + DIV_WIDTH'(1);

    case (state_q)
      IDLE: begin
        sclk_d = cfg_cpol;
        if (can_start_c) begin
          state_d  = SETUP;
          tx_pop_c = 1'b1;
          cpol_d   = cfg_cpol;
          cpha_d   = cfg_cpha;
          lsb_d    = cfg_lsb_first;
          div_d    = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
          cnt_d    = '0;
          edge_d   = '0;
          csn_d    = ~(NUM_CS'(1) << cfg_cs_sel);
          mosi_d   = first_bit(tx_head, cfg_lsb_first);
          txsh_d   = shift_out(tx_head, cfg_lsb_first);
        end
      end
      SETUP: begin
        if (tick_c) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick_c) begin
          sclk_d = ~sclk_q;
          if (sample_c) rxsh_d = shift_in(rxsh_q, miso_bit_c, lsb_q);
          if (update_c) begin
            mosi_d = first_bit(txsh_q, lsb_q);
            txsh_d = shift_out(txsh_q, lsb_q);
          end
          if (edge_q == EDGE_LAST) begin
            state_d      = HOLD;
            edge_d       = '0;
            rx_push_c    = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            edge_d = edge_q + EDGE_W'(1);
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          if (can_start_c) begin
            state_d  = SHIFT;
            tx_pop_c = 1'b1;
            mosi_d   = first_bit(tx_head, lsb_q);
            txsh_d   = shift_out(tx_head, lsb_q);
          end else begin
            state_d = GAP;
            csn_d   = '1;
          end
        end
      end
      GAP: begin
        if (tick_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      div_q        <= DIV_WIDTH'(1);
      cnt_q        <= '0;
      edge_q       <= '0;
      txsh_q       <= '0;
      rxsh_q       <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsb_q        <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      csn_q        <= '1;
      frame_done_q <= 1'b0;
      err_tx_ovf_q <= 1'b0;
      err_rx_udf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      edge_q       <= edge_d;
      txsh_q       <= txsh_d;
      rxsh_q       <= rxsh_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      lsb_q        <= lsb_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      csn_q        <= csn_d;
      frame_done_q <= frame_done_d;
      err_tx_ovf_q <= err_tx_ovf_d;
      err_rx_udf_q <= err_rx_udf_d;
    end
  end

endmodule
